// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port AHB arbiter: round-robin address-phase grant with burst/lock hold and data-phase owner tracking.
// Optional lock watchdog enabled by defining AHB_ARB_LOCK_TIMEOUT_EN.
module ahb_slave_port_arbiter #(
  parameter int NO_OF_MASTERS   = 4,
  parameter int MASTER_ID_WIDTH = $clog2(NO_OF_MASTERS),
  parameter int LOCK_TIMEOUT    = 16
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [NO_OF_MASTERS-1:0]     req,
  input  logic [2*NO_OF_MASTERS-1:0]   htrans_flat,
  input  logic [NO_OF_MASTERS-1:0]     hmastlock,
  input  logic                         hready,
  output logic [NO_OF_MASTERS-1:0]     grant,
  output logic [MASTER_ID_WIDTH-1:0]   addr_owner,
  output logic                         addr_owner_valid,
  output logic [MASTER_ID_WIDTH-1:0]   data_owner,
  output logic                         data_owner_valid,
  output logic                         locked,
  output logic                         lock_timeout
);
  localparam int N  = NO_OF_MASTERS;
  localparam int MW = MASTER_ID_WIDTH;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [MW-1:0]   addr_owner_q, addr_owner_d;
  logic            addr_valid_q, addr_valid_d;
  logic [MW-1:0]   data_owner_q, data_owner_d;
  logic            data_valid_q, data_valid_d;
  logic [MW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            lock_timeout_q, lock_timeout_d;

  logic [1:0]      trans [N];
  logic [N-1:0]    req_eff;
  logic [1:0]      owner_trans;
  logic            hold_owned, hold_locked, hold, timeout_hit;
  logic [N-1:0]    excl_mask;
  logic [MW:0]     pick_lock, pick_any, pick;
  logic [MW-1:0]   win;

  // A request is only real while the master drives a non-IDLE transfer.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign trans[gi]   = htrans_flat[2*gi+1:2*gi];
    assign req_eff[gi] = req[gi] && (trans[gi] != HTRANS_IDLE);
  end

  // Returns {found, index} of the first set bit of mask at or after ptr, wrapping.
  function automatic logic [MW:0] rr_pick(input logic [N-1:0] mask, input logic [MW-1:0] ptr);
    logic [MW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (mask[idx[MW-1:0]]) res = {1'b1, idx[MW-1:0]};
    end
    return res;
  endfunction

  assign owner_trans = trans[addr_owner_q];
  assign hold_owned  = (state_q == ST_OWNED) &&
                       ((owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY));
  assign hold_locked = (state_q == ST_LOCKED) && hmastlock[addr_owner_q];

`ifdef AHB_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  assign timeout_hit = hold_locked && (lock_cnt_q == CW'(LOCK_TIMEOUT - 1));

  // Counts held edges in LOCKED; any re-arbitration restarts it.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (hready) lock_cnt_d = (hold_locked && !timeout_hit) ? lock_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) lock_cnt_q <= '0;
    else          lock_cnt_q <= lock_cnt_d;
  end
`else
  // Never true: without the watchdog a lock is held for as long as the master asserts it.
  assign timeout_hit = (LOCK_TIMEOUT < 0);
`endif

  assign hold      = (hold_owned || hold_locked) && !timeout_hit;
  assign excl_mask = timeout_hit ? (N'(1) << addr_owner_q) : '0;
  assign pick_lock = rr_pick(req_eff & hmastlock & ~excl_mask, rr_ptr_q);
  assign pick_any  = rr_pick(req_eff & ~excl_mask, rr_ptr_q);
  assign pick      = pick_lock[MW] ? pick_lock : pick_any;
  assign win       = pick[MW-1:0];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      addr_owner_q   <= '0;
      addr_valid_q   <= 1'b0;
      data_owner_q   <= '0;
      data_valid_q   <= 1'b0;
      rr_ptr_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      addr_owner_q   <= addr_owner_d;
      addr_valid_q   <= addr_valid_d;
      data_owner_q   <= data_owner_d;
      data_valid_q   <= data_valid_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    addr_owner_d   = addr_owner_q;
    addr_valid_d   = addr_valid_q;
    data_owner_d   = data_owner_q;
    data_valid_d   = data_valid_q;
    rr_ptr_d       = rr_ptr_q;
    lock_timeout_d = 1'b0;
    if (hready) begin
      data_owner_d   = addr_owner_q;
      data_valid_d   = addr_valid_q &&
                       ((owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_SEQ));
      lock_timeout_d = timeout_hit;
      if (!hold) begin
        if (pick[MW]) begin
          grant_d      = N'(1) << win;
          addr_owner_d = win;
          addr_valid_d = 1'b1;
          rr_ptr_d     = (win == MW'(N - 1)) ? '0 : win + 1'b1;
          state_d      = hmastlock[win] ? ST_LOCKED : ST_OWNED;
        end else begin
          // Nobody requests: drop the grant but park addr_owner on the last master.
          grant_d      = '0;
          addr_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    grant            = grant_q;
    addr_owner       = addr_owner_q;
    addr_owner_valid = addr_valid_q;
    data_owner       = data_owner_q;
    data_owner_valid = data_valid_q;
    locked           = (state_q == ST_LOCKED);
    lock_timeout     = lock_timeout_q;
  end
endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Scoreboard bench for ahb_slave_port_arbiter: a cycle model queues expected outputs per driven cycle.
module tb_ahb_slave_port_arbiter;
  localparam int N            = 4;
  localparam int LOCK_TIMEOUT = 16;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] htrans_flat = '0;
  logic [3:0] hmastlock = '0;
  logic       hready = 1'b0;
  logic [3:0] grant;
  logic [1:0] addr_owner, data_owner;
  logic       addr_owner_valid, data_owner_valid, locked, lock_timeout;

  always #5 hclk = ~hclk;

  ahb_slave_port_arbiter #(
    .NO_OF_MASTERS(N),
    .MASTER_ID_WIDTH(2),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .req(req),
    .htrans_flat(htrans_flat),
    .hmastlock(hmastlock),
    .hready(hready),
    .grant(grant),
    .addr_owner(addr_owner),
    .addr_owner_valid(addr_owner_valid),
    .data_owner(data_owner),
    .data_owner_valid(data_owner_valid),
    .locked(locked),
    .lock_timeout(lock_timeout)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] aown;
    logic       aval;
    logic [1:0] down;
    logic       dval;
    logic       lck;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference state: st 0=IDLE 1=OWNED 2=LOCKED
  int m_own, m_ptr, m_st, m_cnt, m_down;
  bit m_aval, m_dval, m_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_ptr = 0; m_st = 0; m_cnt = 0; m_down = 0;
    m_aval = 0; m_dval = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [7:0] t, input logic [3:0] l, input logic h);
    logic [3:0] eff;
    logic [1:0] ot;
    bit hold_l, hold, tmo, found;
    int win, idx;
    exp_t e;
    m_tmo = 1'b0;
    if (h) begin
      for (int i = 0; i < N; i++) eff[i] = r[i] && (t[2*i +: 2] != 2'b00);
      ot     = t[2*m_own +: 2];
      hold_l = (m_st == 2) && l[m_own];
      hold   = ((m_st == 1) && (ot == 2'b11 || ot == 2'b01)) || hold_l;
      tmo    = 1'b0;
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
      if (hold_l && m_cnt == LOCK_TIMEOUT - 1) begin
        tmo = 1'b1; hold = 1'b0; eff[m_own] = 1'b0;
      end
`endif
      m_down = m_own;
      m_dval = m_aval && (ot == 2'b10 || ot == 2'b11);
      m_tmo  = tmo;
      if (hold) begin
        m_cnt = hold_l ? m_cnt + 1 : 0;
      end else begin
        m_cnt = 0; found = 1'b0; win = 0;
        for (int k = 0; k < N && !found; k++) begin
          idx = (m_ptr + k) % N;
          if (eff[idx] && l[idx]) begin found = 1'b1; win = idx; end
        end
        for (int k = 0; k < N && !found; k++) begin
          idx = (m_ptr + k) % N;
          if (eff[idx]) begin found = 1'b1; win = idx; end
        end
        if (found) begin
          m_own = win; m_aval = 1'b1; m_ptr = (win + 1) % N; m_st = l[win] ? 2 : 1;
        end else begin
          m_aval = 1'b0; m_st = 0;
        end
      end
    end
    e.grant = m_aval ? 4'(1 << m_own) : 4'b0000;
    e.aown  = 2'(m_own);
    e.aval  = m_aval;
    e.down  = 2'(m_down);
    e.dval  = m_dval;
    e.lck   = (m_st == 2);
    e.tmo   = m_tmo;
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [7:0] t,
                      input logic [3:0] l, input logic h);
    exp_t e;
    @(negedge hclk);
    req = r; htrans_flat = t; hmastlock = l; hready = h;
    model_edge(r, t, l, h);
    @(posedge hclk);
    #1;
    step_no++;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_grant"}, grant, e.grant);
      check({tag, "_addr_owner"}, addr_owner, e.aown);
      check({tag, "_addr_valid"}, addr_owner_valid, e.aval);
      check({tag, "_data_owner"}, data_owner, e.down);
      check({tag, "_data_valid"}, data_owner_valid, e.dval);
      check({tag, "_locked"}, locked, e.lck);
      check({tag, "_lock_timeout"}, lock_timeout, e.tmo);
    end
    $display("step %0d %s req=%b htrans=%h lock=%b hready=%b -> grant=%b aown=%0d/%b down=%0d/%b locked=%b tmo=%b",
             step_no, tag, r, t, l, h, grant, addr_owner, addr_owner_valid,
             data_owner, data_owner_valid, locked, lock_timeout);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 4'b0000);
    check({tag, "_addr_owner"}, addr_owner, 2'd0);
    check({tag, "_addr_valid"}, addr_owner_valid, 1'b0);
    check({tag, "_data_owner"}, data_owner, 2'd0);
    check({tag, "_data_valid"}, data_owner_valid, 1'b0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_lock_timeout"}, lock_timeout, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge hclk);
    #1;
    check_reset_outputs("reset");
    @(negedge hclk);
    hresetn = 1'b1;

    // Round-robin between masters 1 and 2
    for (int i = 0; i < 4; i++) begin
      step("rr", 4'b0110, 8'hAA, 4'b0000, 1'b1);
      check("rr_alt_grant", grant, (i % 2 == 0) ? 4'b0010 : 4'b0100);
    end
    check("rr_data_owner", data_owner, 2'd1);

    // INCR4 burst from master 1 while master 3 keeps requesting
    step("burst_m3", 4'b1010, 8'b10_00_10_00, 4'b0000, 1'b1);
    check("burst_first_m3", grant, 4'b1000);
    step("burst_ns", 4'b1010, 8'b10_00_10_00, 4'b0000, 1'b1);
    check("burst_nonseq_grant", grant, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step("burst_seq", 4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
      check("burst_hold_grant", grant, 4'b0010);
    end
    step("burst_end", 4'b1010, 8'b10_00_00_00, 4'b0000, 1'b1);
    check("burst_after_grant", grant, 4'b1000);

    // Master 0 locks while idling, master 2 waits
    step("lock_win", 4'b0101, 8'b00_10_00_10, 4'b0001, 1'b1);
    check("lock_win_grant", grant, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step("lock_hold", 4'b0101, 8'b00_10_00_00, 4'b0001, 1'b1);
      check("lock_hold_locked", locked, 1'b1);
      check("lock_hold_grant", grant, 4'b0001);
    end
    step("lock_release", 4'b0101, 8'b00_10_00_00, 4'b0000, 1'b1);
    check("lock_release_grant", grant, 4'b0100);
    check("lock_release_locked", locked, 1'b0);

    // Wait states freeze everything while master 1 starts requesting
    step("ws_same", 4'b0100, 8'b00_10_00_00, 4'b0000, 1'b1);
    check("ws_same_owner_grant", grant, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step("ws_frozen", 4'b0110, 8'b00_10_10_00, 4'b0000, 1'b0);
      check("ws_frozen_grant", grant, 4'b0100);
      check("ws_frozen_aown", addr_owner, 2'd2);
      check("ws_frozen_down", data_owner, 2'd2);
    end
    step("ws_release", 4'b0110, 8'b00_10_10_00, 4'b0000, 1'b1);
    check("ws_release_grant", grant, 4'b0010);

    // All requests drop after master 3 owns the port
    step("park_m3", 4'b1000, 8'b10_00_00_00, 4'b0000, 1'b1);
    check("park_m3_grant", grant, 4'b1000);
    step("park_drop", 4'b0000, 8'b10_00_00_00, 4'b0000, 1'b1);
    check("park_grant", grant, 4'b0000);
    check("park_aval", addr_owner_valid, 1'b0);
    check("park_aown", addr_owner, 2'd3);
    check("park_dval_still", data_owner_valid, 1'b1);
    step("park_idle", 4'b0000, 8'h00, 4'b0000, 1'b1);
    check("park_dval_clear", data_owner_valid, 1'b0);

    // Asynchronous reset in the middle of a burst
    step("rst_ns", 4'b0010, 8'b00_00_10_00, 4'b0000, 1'b1);
    step("rst_seq", 4'b0010, 8'b00_00_11_00, 4'b0000, 1'b1);
    @(negedge hclk);
    hresetn = 1'b0; hready = 1'b0; req = '0; htrans_flat = '0; hmastlock = '0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge hclk);
    hresetn = 1'b1;
    step("after_rst", 4'b0011, 8'hAA, 4'b0000, 1'b1);
    check("after_rst_grant", grant, 4'b0001);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      step("rand", 4'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           1'($urandom_range(0, 3) != 0));
    end

`ifdef AHB_ARB_LOCK_TIMEOUT_EN
    // Master 1 never releases its lock; watchdog hands the port to master 2
    step("tmo_idle", 4'b0000, 8'h00, 4'b0000, 1'b1);
    step("tmo_win", 4'b0110, 8'b00_10_10_00, 4'b0010, 1'b1);
    check("tmo_win_grant", grant, 4'b0010);
    for (int i = 1; i <= LOCK_TIMEOUT; i++) begin
      step("tmo_hold", 4'b0110, 8'b00_10_10_00, 4'b0010, 1'b1);
      check("tmo_grant", grant, (i < LOCK_TIMEOUT) ? 4'b0010 : 4'b0100);
      check("tmo_pulse", lock_timeout, (i < LOCK_TIMEOUT) ? 1'b0 : 1'b1);
    end
    step("tmo_after", 4'b0000, 8'h00, 4'b0000, 1'b1);
    check("tmo_pulse_end", lock_timeout, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
